// File: rtl/paicore_send_xc_if.sv
`default_nettype none
// ============================================================================
//  Module      : paicore_send_xc_if
//  Description : Frame-input stream plus per-link 4-phase request/acknowledge
//                bundle between the PAICORE transmit datapath and its peers.
//  Revision    : 1.0 - initial release
// ============================================================================
interface paicore_send_xc_if #(
    parameter int Channel    = 4,
    parameter int DATA_WIDTH = 64
);
    logic                    s_axis_tvalid;
    logic [DATA_WIDTH-1:0]   s_axis_tdata;
    logic                    s_axis_tlast;
    logic                    s_axis_tready;
    logic [Channel-1:0]      request;
    logic [Channel*32-1:0]   dout;
    logic [Channel-1:0]      acknowledge;

    // Transmit datapath side: consumes frames, drives the chip links.
    modport slave (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, acknowledge,
        output s_axis_tready, request, dout
    );

    // Environment side: frame source plus chip-side responder.
    modport master (
        output s_axis_tvalid, s_axis_tdata, s_axis_tlast, acknowledge,
        input  s_axis_tready, request, dout
    );
endinterface
`default_nettype wire

// File: rtl/paicore_send_xc.sv
`default_nettype none
// ============================================================================
//  Module      : paicore_send_xc
//  Description : Splits 64-bit stream frames into two 32-bit words and sends
//                them over round-robin selected 4-phase req/ack links, with a
//                programmable completion frame count.
//  Revision    : 1.0 - initial release
// ============================================================================
module paicore_send_xc #(
    parameter int Channel    = 4,
    parameter int DATA_WIDTH = 64
) (
    input  logic               s_axis_aclk,
    input  logic               s_axis_aresetn,
    input  logic [Channel-1:0] oen,
    input  logic [31:0]        iFrameNumMax,
    input  logic               i_send_clr,
    paicore_send_xc_if.slave   bus,
    output logic               send_hsked,
    output logic               o_send_busy,
    output logic               o_send_done
);
    localparam int CH_W   = (Channel > 1) ? $clog2(Channel) : 1;
    localparam int WORD_W = DATA_WIDTH / 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_REL  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic                  word_q, word_d;
    logic [WORD_W-1:0]     lo_word_q, lo_word_d;
    logic [31:0]           cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic                  hsked_q, hsked_d;
    logic [Channel-1:0]    request_q, request_d;
    logic [Channel*32-1:0] dout_q, dout_d;
    logic [Channel-1:0]    ack_meta_q, ack_s_q;

    logic                  tready;
    logic                  hsk;
    logic                  frame_done;
    logic                  ack_sel;
    logic [CH_W-1:0]       pick_ch;
    logic [CH_W-1:0]       pick_any;
    logic [CH_W-1:0]       pick_hi;
    logic                  hi_found;
    logic                  unused_tlast;

    // Frame boundaries come from the fixed two-word split, so tlast carries no information.
    assign unused_tlast = bus.s_axis_tlast;

    // Accept only when idle, some link is enabled, not done and not being cleared.
    assign tready = s_axis_aresetn && (state_q == ST_IDLE) && (|oen) && !done_q && !i_send_clr;
    assign hsk    = tready && bus.s_axis_tvalid;

    assign bus.s_axis_tready = tready;
    assign bus.request       = request_q;
    assign bus.dout          = dout_q;
    assign send_hsked        = hsked_q;
    assign o_send_busy       = (state_q != ST_IDLE);
    assign o_send_done       = done_q;

    // Two-flop synchronizer for the asynchronous acknowledge lines.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            ack_meta_q <= '0;
            ack_s_q    <= '0;
        end else begin
            ack_meta_q <= bus.acknowledge;
            ack_s_q    <= ack_meta_q;
        end
    end

    // Round-robin pick: lowest enabled link at or above rr_ptr, else lowest enabled link overall.
    always_comb begin
        pick_any = '0;
        pick_hi  = '0;
        hi_found = 1'b0;
        for (int c = Channel - 1; c >= 0; c--) begin
            if (oen[c]) begin
                pick_any = CH_W'(c);
                if (CH_W'(c) >= rr_ptr_q) begin
                    pick_hi  = CH_W'(c);
                    hi_found = 1'b1;
                end
            end
        end
        pick_ch = hi_found ? pick_hi : pick_any;
    end

    // Synchronized acknowledge of the link owning the in-flight frame.
    always_comb begin
        ack_sel = 1'b0;
        for (int c = 0; c < Channel; c++) begin
            if (CH_W'(c) == ch_q) begin
                ack_sel = ack_s_q[c];
            end
        end
    end

    // Next-state, link drive and frame-count logic.
    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        rr_ptr_d   = rr_ptr_q;
        word_d     = word_q;
        lo_word_d  = lo_word_q;
        request_d  = request_q;
        dout_d     = dout_q;
        hsked_d    = 1'b0;
        frame_done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hsk) begin
                    lo_word_d = bus.s_axis_tdata[WORD_W-1:0];
                    ch_d      = pick_ch;
                    rr_ptr_d  = (pick_ch == CH_W'(Channel - 1)) ? '0 : pick_ch + 1'b1;
                    word_d    = 1'b0;
                    hsked_d   = 1'b1;
                    for (int c = 0; c < Channel; c++) begin
                        if (CH_W'(c) == pick_ch) begin
                            request_d[c]       = 1'b1;
                            dout_d[32*c +: 32] = bus.s_axis_tdata[63:32];
                        end
                    end
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // An acknowledge already high on entry is taken as the acknowledge.
                if (ack_sel) begin
                    for (int c = 0; c < Channel; c++) begin
                        if (CH_W'(c) == ch_q) begin
                            request_d[c] = 1'b0;
                        end
                    end
                    state_d = ST_REL;
                end
            end
            ST_REL: begin
                if (!ack_sel) begin
                    if (!word_q) begin
                        word_d = 1'b1;
                        for (int c = 0; c < Channel; c++) begin
                            if (CH_W'(c) == ch_q) begin
                                request_d[c]       = 1'b1;
                                dout_d[32*c +: 32] = lo_word_q;
                            end
                        end
                        state_d = ST_REQ;
                    end else begin
                        frame_done = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A clear zeroes the counter first; a frame finishing in the same cycle still counts.
        cnt_d  = (i_send_clr ? 32'd0 : cnt_q) + {31'd0, frame_done};
        done_d = (done_q && !i_send_clr) || ((iFrameNumMax != 32'd0) && (cnt_d == iFrameNumMax));
    end

    // State and datapath registers.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state_q   <= ST_IDLE;
            ch_q      <= '0;
            rr_ptr_q  <= '0;
            word_q    <= 1'b0;
            lo_word_q <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            hsked_q   <= 1'b0;
            request_q <= '0;
            dout_q    <= '0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            rr_ptr_q  <= rr_ptr_d;
            word_q    <= word_d;
            lo_word_q <= lo_word_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            hsked_q   <= hsked_d;
            request_q <= request_d;
            dout_q    <= dout_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_paicore_send_xc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_paicore_send_xc
//  Description : Self-checking bench for paicore_send_xc: cycle model,
//                link scoreboard, 4-phase responder and directed scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_paicore_send_xc;
    localparam int CH = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [CH-1:0]     oen;
    logic [31:0]       max_frames;
    logic              clr;
    logic              tvalid;
    logic [63:0]       tdata;
    logic [CH-1:0]     ack;
    logic              send_hsked, busy, done;
    int                ack_delay;
    int                checks = 0;
    int                errors = 0;

    paicore_send_xc_if #(.Channel(CH), .DATA_WIDTH(64)) bus ();
    assign bus.s_axis_tvalid = tvalid;
    assign bus.s_axis_tdata  = tdata;
    assign bus.s_axis_tlast  = 1'b0;
    assign bus.acknowledge   = ack;

    paicore_send_xc #(.Channel(CH), .DATA_WIDTH(64)) dut (
        .s_axis_aclk    (clk),
        .s_axis_aresetn (rst_n),
        .oen            (oen),
        .iFrameNumMax   (max_frames),
        .i_send_clr     (clr),
        .bus            (bus),
        .send_hsked     (send_hsked),
        .o_send_busy    (busy),
        .o_send_done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The link sees an acknowledge two edges after it is driven; a frame occupies one link
    // for two request/acknowledge rounds; frames go to the next enabled link circularly.
    logic [CH-1:0]    a1, a2, seen;
    bit               m_busy, m_wait_ack, m_second, m_done, m_hsk, inc;
    int               m_ch, m_rr;
    logic [31:0]      m_cnt, m_lo;
    logic [CH-1:0]    m_req;
    logic [CH*32-1:0] m_dout;
    int               exp_link[$];
    logic [31:0]      exp_word[$];

    function automatic bit m_ready();
        return (rst_n === 1'b1) && !m_busy && (oen != '0) && !m_done && !clr;
    endfunction

    function automatic int pick_link(input int from);
        for (int k = 0; k < CH; k++) begin
            if (oen[(from + k) % CH]) return (from + k) % CH;
        end
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1 = '0; a2 = '0; m_busy = 0; m_wait_ack = 0; m_second = 0; m_done = 0;
            m_hsk = 0; m_ch = 0; m_rr = 0; m_cnt = 0; m_lo = 0; m_req = '0; m_dout = '0;
            exp_link.delete(); exp_word.delete();
        end else begin
            seen = a2;
            inc = 0;
            m_hsk = 0;
            if (!m_busy) begin
                if (tvalid && m_ready()) begin
                    m_ch = pick_link(m_rr);
                    m_rr = (m_ch + 1) % CH;
                    m_lo = tdata[31:0];
                    m_busy = 1; m_wait_ack = 1; m_second = 0; m_hsk = 1;
                    m_req[m_ch] = 1'b1;
                    m_dout[32*m_ch +: 32] = tdata[63:32];
                    exp_link.push_back(m_ch); exp_word.push_back(tdata[63:32]);
                    exp_link.push_back(m_ch); exp_word.push_back(tdata[31:0]);
                end
            end else if (m_wait_ack) begin
                if (seen[m_ch]) begin
                    m_req[m_ch] = 1'b0;
                    m_wait_ack = 0;
                end
            end else if (!seen[m_ch]) begin
                if (!m_second) begin
                    m_second = 1; m_wait_ack = 1;
                    m_req[m_ch] = 1'b1;
                    m_dout[32*m_ch +: 32] = m_lo;
                end else begin
                    m_busy = 0;
                    inc = 1;
                end
            end
            if (clr) m_cnt = 0;
            if (inc) m_cnt = m_cnt + 1;
            if (clr) m_done = 0;
            if (max_frames != 0 && m_cnt == max_frames) m_done = 1;
            a2 = a1;
            a1 = ack;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        check("tready", bus.s_axis_tready, m_ready());
        check("send_hsked", send_hsked, m_hsk);
        check("busy", busy, m_busy);
        check("done", done, m_done);
        check("request", bus.request, m_req);
        check("dout", bus.dout, m_dout);
    end

    // ---------------- link monitor / scoreboard ----------------
    logic [CH-1:0]    prev_req;
    logic [CH*32-1:0] prev_dout;
    int               dl_link[$];
    logic [31:0]      dl_word[$];
    int               rises = 0;
    int               hs_count = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_req  = '0;
            prev_dout = '0;
        end else begin
            if (send_hsked) hs_count++;
            check("one_request", ($countones(bus.request) <= 1), 1);
            for (int i = 0; i < CH; i++) begin
                if (bus.request[i] && !prev_req[i]) begin
                    rises++;
                    dl_link.push_back(i);
                    dl_word.push_back(bus.dout[32*i +: 32]);
                    check("ack_low_at_req_rise", ack[i], 0);
                    if (exp_link.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL sb_extra: actual link %0d word %0h required none", i, bus.dout[32*i +: 32]);
                    end else begin
                        check("sb_link", i, exp_link.pop_front());
                        check("sb_word", bus.dout[32*i +: 32], exp_word.pop_front());
                    end
                end
                if (!bus.request[i] && prev_req[i])
                    check("ack_high_at_req_fall", ack[i], 1);
                if (bus.request[i] && prev_req[i])
                    check("dout_stable", bus.dout[32*i +: 32], prev_dout[32*i +: 32]);
            end
            prev_req  = bus.request;
            prev_dout = bus.dout;
        end
    end

    // ---------------- chip-side responder ----------------
    int rcnt [CH];
    always @(posedge clk) begin
        #2;
        for (int i = 0; i < CH; i++) begin
            if (!rst_n) begin
                ack[i] = 1'b0; rcnt[i] = 0;
            end else if (bus.request[i] != ack[i]) begin
                if (rcnt[i] >= ack_delay) begin
                    ack[i] = bus.request[i]; rcnt[i] = 0;
                end else begin
                    rcnt[i]++;
                end
            end else begin
                rcnt[i] = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_expect(input logic [63:0] d, input int max_wait, input bit exp_acc, input string name);
        bit accepted;
        accepted = 0;
        tvalid = 1'b1;
        tdata  = d;
        for (int n = 0; n < max_wait; n++) begin
            @(negedge clk);
            if (bus.s_axis_tready) begin
                accepted = 1;
                break;
            end
        end
        @(posedge clk); #1;
        tvalid = 1'b0;
        check(name, accepted, exp_acc);
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || exp_link.size() != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("idle_within_limit", (n < limit), 1);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    int base, hs_base, rise_base, l2;
    int rr_exp [5] = '{0, 1, 3, 0, 1};

    initial begin
        oen = 4'b0001; max_frames = 0; clr = 0; tvalid = 0; tdata = 0; ack = '0; ack_delay = 1;
        repeat (2) @(posedge clk); #1;
        check("rst_tready", bus.s_axis_tready, 0);
        check("rst_request", bus.request, 0);
        check("rst_dout", bus.dout, 0);
        check("rst_hsked", send_hsked, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single frame on link 0.
        base = dl_link.size(); hs_base = hs_count;
        send_expect(64'h1122_3344_5566_7788, 50, 1, "t1_accept");
        wait_idle(200);
        check("t1_link_w0", dl_link[base], 0);
        check("t1_word_w0", dl_word[base], 32'h1122_3344);
        check("t1_link_w1", dl_link[base+1], 0);
        check("t1_word_w1", dl_word[base+1], 32'h5566_7788);
        check("t1_hsk_pulses", hs_count - hs_base, 1);
        // Counter is 1: programming a limit of 1 must raise done.
        max_frames = 1;
        @(posedge clk); #1;
        check("t1_count_is_1", done, 1);
        max_frames = 0;
        pulse_clr();
        check("t1_clr_done", done, 0);

        // Round robin over 4'b1011.
        do_reset();
        oen = 4'b1011;
        base = dl_link.size();
        for (int f = 0; f < 5; f++)
            send_expect({32'hA000_0000 + f, 32'hB000_0000 + f}, 100, 1, "t2_accept");
        wait_idle(300);
        for (int f = 0; f < 5; f++) begin
            check("t2_rr_w0", dl_link[base + 2*f], rr_exp[f]);
            check("t2_rr_w1", dl_link[base + 2*f + 1], rr_exp[f]);
        end
        l2 = 0;
        for (int k = base; k < dl_link.size(); k++) if (dl_link[k] == 2) l2++;
        check("t2_no_link2", l2, 0);

        // Frame limit, blocking, clear.
        oen = 4'b0001;
        pulse_clr();
        max_frames = 3;
        for (int f = 0; f < 3; f++)
            send_expect({32'hC000_0000 + f, 32'hD000_0000 + f}, 100, 1, "t3_accept");
        wait_idle(300);
        check("t3_done_set", done, 1);
        check("t3_tready_low", bus.s_axis_tready, 0);
        send_expect(64'hDEAD_BEEF_0000_0004, 20, 0, "t3_blocked");
        pulse_clr();
        check("t3_done_cleared", done, 0);
        send_expect(64'hC000_0004_D000_0004, 50, 1, "t3_accept_after_clr");
        send_expect(64'hC000_0005_D000_0005, 50, 1, "t3_accept_5");
        wait_idle(300);
        check("t3_count2_not_done", done, 0);
        send_expect(64'hC000_0006_D000_0006, 50, 1, "t3_accept_6");
        wait_idle(300);
        check("t3_count3_done", done, 1);
        max_frames = 0;
        pulse_clr();

        // Slow responder with random source gaps.
        ack_delay = 20;
        oen = 4'b1111;
        hs_base = hs_count; rise_base = rises;
        for (int f = 0; f < 4; f++) begin
            repeat ($urandom_range(0, 4)) @(posedge clk);
            #1;
            send_expect({$urandom, $urandom}, 400, 1, "t4_accept");
        end
        wait_idle(1000);
        check("t4_frames", hs_count - hs_base, 4);
        check("t4_words", rises - rise_base, 8);

        // oen change mid-frame.
        do_reset();
        ack_delay = 5;
        oen = 4'b0001;
        base = dl_link.size();
        send_expect(64'h0102_0304_0506_0708, 50, 1, "t5_accept_a");
        repeat (3) @(posedge clk);
        #1 oen = 4'b0100;
        wait_idle(300);
        send_expect(64'h1112_1314_1516_1718, 50, 1, "t5_accept_b");
        wait_idle(300);
        check("t5_a_w0", dl_link[base], 0);
        check("t5_a_w1", dl_link[base+1], 0);
        check("t5_b_w0", dl_link[base+2], 2);
        check("t5_b_w1", dl_link[base+3], 2);

        // Reset while the second word is requested.
        do_reset();
        ack_delay = 20;
        oen = 4'b0001;
        rise_base = rises;
        send_expect(64'h2222_2222_3333_3333, 50, 1, "t6_accept");
        for (int n = 0; n < 300 && (rises - rise_base) < 2; n++) @(negedge clk);
        check("t6_reached_word1", rises - rise_base, 2);
        #3 rst_n = 1'b0;
        #1;
        check("t6_rst_request", bus.request, 0);
        check("t6_rst_dout", bus.dout, 0);
        check("t6_rst_tready", bus.s_axis_tready, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_hsked", send_hsked, 0);
        check("t6_rst_done", done, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        ack_delay = 1;
        oen = 4'b1111;
        base = dl_link.size();
        send_expect(64'h4444_5555_6666_7777, 50, 1, "t6_accept_after");
        wait_idle(300);
        check("t6_after_link", dl_link[base], 0);
        check("t6_after_w0", dl_word[base], 32'h4444_5555);
        check("t6_after_w1", dl_word[base+1], 32'h6666_7777);

        check("sb_drained", exp_link.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
